// File: rtl/axi_slave_default.sv
// AXI4 default slave: completes every write and read burst with a fixed error response
// so that masters addressing unmapped space never stall; counts absorbed transactions.
module axi_slave_default #(
    parameter logic [1:0]  RESP_CODE     = 2'b11,
    parameter logic [31:0] RD_DATA_VALUE = 32'hDEAD_BEEF
) (
    input  logic        SLAVE_CLK,
    input  logic        SLAVE_RSTN,
    input  logic [1:0]  SLAVE_WR_ADDR_ID,
    input  logic [31:0] SLAVE_WR_ADDR,
    input  logic [7:0]  SLAVE_WR_ADDR_LEN,
    input  logic [1:0]  SLAVE_WR_ADDR_BURST,
    input  logic        SLAVE_WR_ADDR_VALID,
    output logic        SLAVE_WR_ADDR_READY,
    input  logic [31:0] SLAVE_WR_DATA,
    input  logic [3:0]  SLAVE_WR_DATA_STRB,
    input  logic        SLAVE_WR_DATA_LAST,
    input  logic        SLAVE_WR_DATA_VALID,
    output logic        SLAVE_WR_DATA_READY,
    output logic [1:0]  SLAVE_WR_BACK_ID,
    output logic [1:0]  SLAVE_WR_BACK_RESP,
    output logic        SLAVE_WR_BACK_VALID,
    input  logic        SLAVE_WR_BACK_READY,
    input  logic [1:0]  SLAVE_RD_ADDR_ID,
    input  logic [31:0] SLAVE_RD_ADDR,
    input  logic [7:0]  SLAVE_RD_ADDR_LEN,
    input  logic [1:0]  SLAVE_RD_ADDR_BURST,
    input  logic        SLAVE_RD_ADDR_VALID,
    output logic        SLAVE_RD_ADDR_READY,
    output logic [1:0]  SLAVE_RD_BACK_ID,
    output logic [31:0] SLAVE_RD_DATA,
    output logic [1:0]  SLAVE_RD_DATA_RESP,
    output logic        SLAVE_RD_DATA_LAST,
    output logic        SLAVE_RD_DATA_VALID,
    input  logic        SLAVE_RD_DATA_READY,
    output logic [15:0] WR_TXN_CNT,
    output logic [15:0] RD_TXN_CNT
);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    w_state_t    w_state_r;
    w_state_t    w_state_s;
    r_state_t    r_state_r;
    r_state_t    r_state_s;
    logic [1:0]  wr_id_r;
    logic [1:0]  rd_id_r;
    logic [7:0]  rd_len_r;
    logic [7:0]  beat_r;
    logic [15:0] wr_txn_cnt_r;
    logic [15:0] rd_txn_cnt_r;
    logic        aw_hs_s;
    logic        w_hs_s;
    logic        b_hs_s;
    logic        ar_hs_s;
    logic        r_hs_s;
    logic        r_last_s;
    logic        unused_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Handshakes are qualified by state only, so READY never depends on VALID.
    assign aw_hs_s  = SLAVE_WR_ADDR_VALID && (w_state_r == W_IDLE);
    assign w_hs_s   = SLAVE_WR_DATA_VALID && (w_state_r == W_DATA);
    assign b_hs_s   = SLAVE_WR_BACK_READY && (w_state_r == W_RESP);
    assign ar_hs_s  = SLAVE_RD_ADDR_VALID && (r_state_r == R_IDLE);
    assign r_hs_s   = SLAVE_RD_DATA_READY && (r_state_r == R_DATA);
    assign r_last_s = (r_state_r == R_DATA) && (beat_r == rd_len_r);

    // Write FSM next-state decode.
    always_comb begin
        w_state_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s) w_state_s = W_DATA;
                else         w_state_s = W_IDLE;
            end
            W_DATA: begin
                if (w_hs_s && SLAVE_WR_DATA_LAST) w_state_s = W_RESP;
                else                              w_state_s = W_DATA;
            end
            W_RESP: begin
                if (b_hs_s) w_state_s = W_IDLE;
                else        w_state_s = W_RESP;
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    // Read FSM next-state decode.
    always_comb begin
        r_state_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) r_state_s = R_DATA;
                else         r_state_s = R_IDLE;
            end
            R_DATA: begin
                if (r_hs_s && r_last_s) r_state_s = R_IDLE;
                else                    r_state_s = R_DATA;
            end
            default: r_state_s = R_IDLE;
        endcase
    end

    // State registers for both FSMs.
    always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
        if (!SLAVE_RSTN) begin
            w_state_r <= W_IDLE;
            r_state_r <= R_IDLE;
        end else begin
            w_state_r <= w_state_s;
            r_state_r <= r_state_s;
        end
    end

    // Latched transaction attributes and read beat counter.
    always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
        if (!SLAVE_RSTN) begin
            wr_id_r  <= 2'd0;
            rd_id_r  <= 2'd0;
            rd_len_r <= 8'd0;
            beat_r   <= 8'd0;
        end else begin
            if (aw_hs_s) begin
                wr_id_r <= SLAVE_WR_ADDR_ID;
            end
            if (ar_hs_s) begin
                rd_id_r  <= SLAVE_RD_ADDR_ID;
                rd_len_r <= SLAVE_RD_ADDR_LEN;
                beat_r   <= 8'd0;
            end else if (r_hs_s) begin
                beat_r <= beat_r + 8'd1;
            end
        end
    end

    // Saturating transaction counters, bumped on the completing handshake.
    always_ff @(posedge SLAVE_CLK or negedge SLAVE_RSTN) begin
        if (!SLAVE_RSTN) begin
            wr_txn_cnt_r <= 16'd0;
            rd_txn_cnt_r <= 16'd0;
        end else begin
            if (b_hs_s) begin
                wr_txn_cnt_r <= sat_inc(wr_txn_cnt_r);
            end
            if (r_hs_s && r_last_s) begin
                rd_txn_cnt_r <= sat_inc(rd_txn_cnt_r);
            end
        end
    end

    assign SLAVE_WR_ADDR_READY = (w_state_r == W_IDLE);
    assign SLAVE_WR_DATA_READY = (w_state_r == W_DATA);
    assign SLAVE_WR_BACK_VALID = (w_state_r == W_RESP);
    assign SLAVE_WR_BACK_ID    = wr_id_r;
    assign SLAVE_WR_BACK_RESP  = RESP_CODE;
    assign SLAVE_RD_ADDR_READY = (r_state_r == R_IDLE);
    assign SLAVE_RD_DATA_VALID = (r_state_r == R_DATA);
    assign SLAVE_RD_DATA_LAST  = r_last_s;
    assign SLAVE_RD_BACK_ID    = rd_id_r;
    assign SLAVE_RD_DATA       = RD_DATA_VALUE;
    assign SLAVE_RD_DATA_RESP  = RESP_CODE;
    assign WR_TXN_CNT          = wr_txn_cnt_r;
    assign RD_TXN_CNT          = rd_txn_cnt_r;

    // Address, burst and write payload carry no meaning for an error responder.
    assign unused_s = ^{SLAVE_WR_ADDR, SLAVE_WR_ADDR_LEN, SLAVE_WR_ADDR_BURST,
                        SLAVE_WR_DATA, SLAVE_WR_DATA_STRB,
                        SLAVE_RD_ADDR, SLAVE_RD_ADDR_BURST};

endmodule

// File: tb/tb_axi_slave_default.sv
// Scoreboard bench for axi_slave_default: tasks queue expected B/R responses, a negedge
// monitor pops and compares them at every handshake.
module tb_axi_slave_default;

    logic        clk = 1'b0;
    logic        rstn;
    logic [1:0]  aw_id;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [1:0]  aw_burst;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        w_last;
    logic        w_valid;
    logic        w_ready;
    logic [1:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;
    logic [1:0]  ar_id;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [1:0]  ar_burst;
    logic        ar_valid;
    logic        ar_ready;
    logic [1:0]  r_id;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        r_valid;
    logic        r_ready;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;

    typedef struct packed {
        logic [1:0] id;
        logic [1:0] resp;
    } b_exp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic [1:0]  id;
        logic        last;
    } r_exp_t;

    b_exp_t b_exp_q[$];
    r_exp_t r_exp_q[$];
    int     tests = 0;
    int     fails = 0;
    bit     r_stall = 1'b0;
    logic   r_stall_last = 1'b0;
    logic [1:0] r_stall_id = 2'd0;

    axi_slave_default dut (
        .SLAVE_CLK          (clk),
        .SLAVE_RSTN         (rstn),
        .SLAVE_WR_ADDR_ID   (aw_id),
        .SLAVE_WR_ADDR      (aw_addr),
        .SLAVE_WR_ADDR_LEN  (aw_len),
        .SLAVE_WR_ADDR_BURST(aw_burst),
        .SLAVE_WR_ADDR_VALID(aw_valid),
        .SLAVE_WR_ADDR_READY(aw_ready),
        .SLAVE_WR_DATA      (w_data),
        .SLAVE_WR_DATA_STRB (w_strb),
        .SLAVE_WR_DATA_LAST (w_last),
        .SLAVE_WR_DATA_VALID(w_valid),
        .SLAVE_WR_DATA_READY(w_ready),
        .SLAVE_WR_BACK_ID   (b_id),
        .SLAVE_WR_BACK_RESP (b_resp),
        .SLAVE_WR_BACK_VALID(b_valid),
        .SLAVE_WR_BACK_READY(b_ready),
        .SLAVE_RD_ADDR_ID   (ar_id),
        .SLAVE_RD_ADDR      (ar_addr),
        .SLAVE_RD_ADDR_LEN  (ar_len),
        .SLAVE_RD_ADDR_BURST(ar_burst),
        .SLAVE_RD_ADDR_VALID(ar_valid),
        .SLAVE_RD_ADDR_READY(ar_ready),
        .SLAVE_RD_BACK_ID   (r_id),
        .SLAVE_RD_DATA      (r_data),
        .SLAVE_RD_DATA_RESP (r_resp),
        .SLAVE_RD_DATA_LAST (r_last),
        .SLAVE_RD_DATA_VALID(r_valid),
        .SLAVE_RD_DATA_READY(r_ready),
        .WR_TXN_CNT         (wr_cnt),
        .RD_TXN_CNT         (rd_cnt)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every handshake seen at the negedge is compared against the queue head.
    initial begin
        b_exp_t be;
        r_exp_t re;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (r_stall) begin
                    chk("r_hold_valid", 32'(r_valid), 32'd1);
                    chk("r_hold_last", 32'(r_last), 32'(r_stall_last));
                    chk("r_hold_id", 32'(r_id), 32'(r_stall_id));
                end
                if (r_valid && r_ready) begin
                    if (r_exp_q.size() == 0) begin
                        chk("r_unexpected_beat", 32'd1, 32'd0);
                    end else begin
                        re = r_exp_q.pop_front();
                        chk("r_data", r_data, re.data);
                        chk("r_resp", 32'(r_resp), 32'(re.resp));
                        chk("r_id", 32'(r_id), 32'(re.id));
                        chk("r_last", 32'(r_last), 32'(re.last));
                    end
                end
                if (b_valid && b_ready) begin
                    if (b_exp_q.size() == 0) begin
                        chk("b_unexpected", 32'd1, 32'd0);
                    end else begin
                        be = b_exp_q.pop_front();
                        chk("b_id", 32'(b_id), 32'(be.id));
                        chk("b_resp", 32'(b_resp), 32'(be.resp));
                    end
                end
            end
            r_stall      = rstn && r_valid && !r_ready;
            r_stall_last = r_last;
            r_stall_id   = r_id;
        end
    end

    task automatic do_write(input logic [1:0] id, input int nbeats, input int bdelay,
                            input logic [15:0] exp_cnt);
        int n;
        b_exp_q.push_back('{id: id, resp: 2'b11});
        aw_id    = id;
        aw_len   = 8'(nbeats - 1);
        aw_addr  = 32'h8000_0100;
        aw_burst = 2'b01;
        aw_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!aw_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("aw_accept", 32'(aw_ready), 32'd1);
        @(posedge clk);
        #1 aw_valid = 1'b0;
        chk("aw_ready_drop", 32'(aw_ready), 32'd0);
        chk("w_ready_rise", 32'(w_ready), 32'd1);
        for (int i = 0; i < nbeats; i++) begin
            w_data  = $urandom;
            w_strb  = 4'hF;
            w_last  = (i == nbeats - 1);
            w_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!w_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("w_accept", 32'(w_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
        chk("b_valid_rise", 32'(b_valid), 32'd1);
        for (int i = 0; i < bdelay; i++) begin
            @(negedge clk);
            chk("b_valid_hold", 32'(b_valid), 32'd1);
            chk("b_id_hold", 32'(b_id), 32'(id));
            @(posedge clk);
            #1;
        end
        b_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!b_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("b_present", 32'(b_valid), 32'd1);
        @(posedge clk);
        #1 b_ready = 1'b0;
        chk("wr_txn_cnt", 32'(wr_cnt), 32'(exp_cnt));
        chk("aw_ready_back", 32'(aw_ready), 32'd1);
        chk("b_valid_fall", 32'(b_valid), 32'd0);
    endtask

    task automatic do_read(input logic [1:0] id, input logic [7:0] len, input bit toggle,
                           input logic [15:0] exp_cnt);
        int  n;
        int  beats;
        int  cyc;
        bit  done;
        for (int i = 0; i <= int'(len); i++) begin
            r_exp_q.push_back('{data: 32'hDEAD_BEEF, resp: 2'b11, id: id, last: (i == int'(len))});
        end
        ar_id    = id;
        ar_len   = len;
        ar_addr  = 32'h9000_0000;
        ar_burst = 2'b10;
        ar_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ar_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ar_accept", 32'(ar_ready), 32'd1);
        @(posedge clk);
        #1 ar_valid = 1'b0;
        chk("r_valid_rise", 32'(r_valid), 32'd1);
        chk("ar_ready_drop", 32'(ar_ready), 32'd0);
        beats = 0;
        cyc   = 0;
        done  = 1'b0;
        while (!done && cyc < 2000) begin
            r_ready = (toggle && (cyc % 2 != 0)) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (r_valid && r_ready) begin
                beats++;
                if (r_last) done = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        r_ready = 1'b0;
        chk("r_beat_count", 32'(beats), 32'(int'(len) + 1));
        chk("rd_txn_cnt", 32'(rd_cnt), 32'(exp_cnt));
        chk("ar_ready_back", 32'(ar_ready), 32'd1);
        chk("r_valid_fall", 32'(r_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn     = 1'b0;
        aw_id    = 2'd0;  aw_addr = 32'd0;  aw_len = 8'd0;  aw_burst = 2'd0;  aw_valid = 1'b0;
        w_data   = 32'd0; w_strb  = 4'd0;   w_last = 1'b0;  w_valid  = 1'b0;  b_ready  = 1'b0;
        ar_id    = 2'd0;  ar_addr = 32'd0;  ar_len = 8'd0;  ar_burst = 2'd0;  ar_valid = 1'b0;
        r_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Reset values, and W offered before AW must not be accepted.
        w_valid = 1'b1;
        @(negedge clk);
        chk("rst_aw_ready", 32'(aw_ready), 32'd1);
        chk("rst_ar_ready", 32'(ar_ready), 32'd1);
        chk("rst_w_ready", 32'(w_ready), 32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_r_valid", 32'(r_valid), 32'd0);
        chk("rst_r_last", 32'(r_last), 32'd0);
        chk("rst_b_id", 32'(b_id), 32'd0);
        chk("rst_r_id", 32'(r_id), 32'd0);
        chk("rst_b_resp", 32'(b_resp), 32'd3);
        chk("rst_r_resp", 32'(r_resp), 32'd3);
        chk("rst_r_data", r_data, 32'hDEAD_BEEF);
        chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
        @(posedge clk);
        #1 w_valid = 1'b0;
        chk("w_before_aw_ignored", 32'(w_ready), 32'd0);

        do_write(2'd2, 4, 5, 16'd1);
        do_read(2'd1, 8'd7, 1'b1, 16'd1);

        fork
            do_read(2'd2, 8'd255, 1'b0, 16'd2);
            do_write(2'd1, 1, 0, 16'd2);
        join

        // Asynchronous reset while beat 3 of an 8-beat read is on offer.
        for (int i = 0; i < 8; i++) begin
            r_exp_q.push_back('{data: 32'hDEAD_BEEF, resp: 2'b11, id: 2'd3, last: (i == 7)});
        end
        ar_id    = 2'd3;
        ar_len   = 8'd7;
        ar_valid = 1'b1;
        @(posedge clk);
        #1 ar_valid = 1'b0;
        r_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_r_valid", 32'(r_valid), 32'd1);
        chk("pre_rst_r_queue", 32'(r_exp_q.size()), 32'd6);
        #1 rstn = 1'b0;
        #1;
        chk("async_rst_r_valid", 32'(r_valid), 32'd0);
        chk("async_rst_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("async_rst_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("async_rst_ar_ready", 32'(ar_ready), 32'd1);
        r_ready = 1'b0;
        r_exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        do_read(2'd0, 8'd0, 1'b0, 16'd1);

        // Write counter saturation.
        @(negedge clk);
        force dut.wr_txn_cnt_r = 16'hFFFE;
        @(negedge clk);
        chk("forced_wr_cnt", 32'(wr_cnt), 32'h0000_FFFE);
        release dut.wr_txn_cnt_r;
        @(posedge clk);
        #1;
        do_write(2'd3, 1, 0, 16'hFFFF);
        do_write(2'd0, 2, 1, 16'hFFFF);
        do_write(2'd1, 1, 0, 16'hFFFF);

        repeat (3) @(posedge clk);
        #1;
        chk("b_queue_drained", 32'(b_exp_q.size()), 32'd0);
        chk("r_queue_drained", 32'(r_exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_slave_default.md
# axi_slave_default

AXI4 default responder: the slave-side endpoint for any unused slave port on the AXI interconnect, and the counterpart of the master-side tie-off stub. Unlike a pure tie-off, it completes every transaction so a master addressing an unmapped region never hangs. It accepts writes and reads of any length, consumes every write beat, and returns a write response or LEN+1 read beats, each carrying a fixed error response. Two saturating counters expose how many transactions it has absorbed.

## Interface
- RESP_CODE, 2'b11, BRESP/RRESP value returned on every response (DECERR).
- RD_DATA_VALUE, 32'hDEAD_BEEF, constant read data on every read beat.
- SLAVE_CLK  in  1  block clock; all logic is in this domain.
- SLAVE_RSTN  in  1  reset: asynchronous and active-low.
- SLAVE_WR_ADDR_ID / _ADDR / _ADDR_LEN / _ADDR_BURST  in  2/32/8/2  AW channel; only ID is used.
- SLAVE_WR_ADDR_VALID  in  1;  SLAVE_WR_ADDR_READY  out  1.
- SLAVE_WR_DATA / _STRB  in  32/4  ignored.
- SLAVE_WR_DATA_LAST  in  1;  SLAVE_WR_DATA_VALID  in  1;  SLAVE_WR_DATA_READY  out  1.
- SLAVE_WR_BACK_ID  out  2;  SLAVE_WR_BACK_RESP  out  2;  SLAVE_WR_BACK_VALID  out  1;  SLAVE_WR_BACK_READY  in  1.
- SLAVE_RD_ADDR_ID / _ADDR / _ADDR_LEN / _ADDR_BURST  in  2/32/8/2  AR channel; ID and LEN are used.
- SLAVE_RD_ADDR_VALID  in  1;  SLAVE_RD_ADDR_READY  out  1.
- SLAVE_RD_BACK_ID  out  2;  SLAVE_RD_DATA  out  32;  SLAVE_RD_DATA_RESP  out  2.
- SLAVE_RD_DATA_LAST  out  1;  SLAVE_RD_DATA_VALID  out  1;  SLAVE_RD_DATA_READY  in  1.
- WR_TXN_CNT  out  16  number of completed B handshakes, saturating.
- RD_TXN_CNT  out  16  number of completed read bursts (LAST handshakes), saturating.

## Operation
- The write FSM and read FSM are independent and may run concurrently.
- All READY/VALID outputs decode from state registers only; there is no combinational input-to-output path.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: WR_ADDR_READY=1. On AW handshake, latch ID and go to W_DATA.
  - W_DATA: WR_DATA_READY=1. Each W handshake is consumed. A handshake with LAST=1 moves to W_RESP. LEN is not checked; only LAST ends the burst.
  - W_RESP: WR_BACK_VALID=1, BACK_ID=latched ID, BACK_RESP=RESP_CODE, all held stable until BACK_READY. On the handshake, go to W_IDLE and increment WR_TXN_CNT.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: RD_ADDR_READY=1. On AR handshake, latch ID and LEN, clear the 8-bit beat counter, go to R_DATA.
  - R_DATA: RD_DATA_VALID=1, RD_DATA=RD_DATA_VALUE, RD_DATA_RESP=RESP_CODE, RD_BACK_ID=latched ID, RD_DATA_LAST=(beat==LEN).
  - Each R handshake increments beat. The LAST handshake returns to R_IDLE and increments RD_TXN_CNT.
- LEN=255 gives 256 beats; beat is 8 bits and never wraps within a burst.
- Counters saturate at 16'hFFFF.
- BURST and ADDR are ignored for every burst type.
- Reset (asynchronous, any time, including mid-burst) forces both FSMs to idle and clears latched ID, LEN, beat and both counters. Any in-flight burst is abandoned.
- Reset values of outputs:
  - WR_ADDR_READY=1, RD_ADDR_READY=1.
  - WR_DATA_READY=0, WR_BACK_VALID=0, RD_DATA_VALID=0, RD_DATA_LAST=0.
  - WR_BACK_ID=0, RD_BACK_ID=0.
  - WR_BACK_RESP=RESP_CODE, RD_DATA_RESP=RESP_CODE, RD_DATA=RD_DATA_VALUE.
  - WR_TXN_CNT=0, RD_TXN_CNT=0.

## Timing
- AW handshake at edge T: WR_ADDR_READY=0 and WR_DATA_READY=1 from T.
- W beats arriving before AW are not accepted (WR_DATA_READY=0 in W_IDLE).
- LAST W handshake at edge T: WR_BACK_VALID=1 from T, so B VALID rises 1 cycle after the last beat.
- B handshake at edge T: WR_ADDR_READY=1 from T. Minimum write turnaround is LEN+3 cycles per burst.
- AR handshake at edge T: RD_DATA_VALID=1 from T, so the first beat is offered 1 cycle after AR.
- With RD_DATA_READY held at 1, the LAST handshake is at T+LEN+1 and RD_ADDR_READY=1 from that edge.
- Backpressure: VALID, DATA, LAST and ID are held unchanged while READY=0.
- Counters update on the same edge as the qualifying handshake.

## Test plan
- Reset, then idle: all outputs at their listed reset values; both ADDR_READY=1, both VALIDs=0.
- Write ID=2, LEN=3, 4 W beats with LAST on the 4th:
  - expect BVALID one cycle after the 4th beat, BID=2, BRESP=2'b11;
  - with BREADY delayed 5 cycles, BVALID is held and WR_TXN_CNT becomes 1 on the handshake.
- Read ID=1, LEN=7, RREADY toggling 1/0:
  - expect exactly 8 beats of 32'hDEAD_BEEF, RRESP=2'b11, RID=1;
  - LAST only on the 8th beat; RD_TXN_CNT=1.
- Read LEN=255 concurrent with write LEN=0:
  - expect 256 read beats with LAST only on beat 256;
  - the write completes independently with 1 B response.
- Assert SLAVE_RSTN low asynchronously mid-read (beat 3 of 8):
  - expect RVALID=0 immediately and counters=0;
  - after release, a new read LEN=0 returns 1 beat with LAST=1.
- Force WR_TXN_CNT to 16'hFFFE, then complete 3 writes: expect 16'hFFFF, held (no wrap).
